stack_calc_core: RTL and testbench
==================================

STACK_CALC_CORE -- requirements
Module: stack_calc_core

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning stack entries of 8 bits each; legal range 2..16.
REQ-002 SHALL have io_in[0]  input  1  clk; the single clock; all state updates on its rising edge.
REQ-003 SHALL have io_in[1]  input  1  rst; synchronous, active-high reset.
REQ-004 SHALL have io_in[2]  input  1  strobe; a command is accepted on its rising edge.
REQ-005 SHALL have io_in[3]  input  1  mode; 0 = push payload, 1 = execute opcode payload.
REQ-006 SHALL have io_in[7:4]  input  4  payload; nibble data or opcode.
REQ-007 SHALL have io_out  output  8  display; top of stack, or error code in ERROR.

Function
REQ-008 SHALL register strobe into strobe_q every cycle.
REQ-009 SHALL accept a command only in a cycle with io_in[2]=1 and strobe_q=0; a held-high strobe yields exactly one command.
REQ-010 SHALL apply an accepted command on that same clock edge, so io_out reflects the result one cycle after the sampled edge.
REQ-011 SHALL implement FSM states RUN and ERROR, with RUN->ERROR on a detected fault and ERROR->RUN only on CLR.
REQ-012 Push (mode=0) SHALL write {4'b0,payload} above the top and increment depth; with depth==DEPTH it SHALL raise overflow (code 1).
REQ-013 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; each pops b (top) then a and pushes the result, depth-1, needing depth>=2.
REQ-014 Opcodes: 5 NEG top=-top; 7 DROP depth-1; 9 SHL4 top={top[3:0],4'h0}; each needs depth>=1.
REQ-015 Opcode 6 DUP SHALL need depth>=1 and depth<DEPTH, with a full stack giving overflow (code 1); opcode 8 SWAP SHALL need depth>=2.
REQ-016 All arithmetic SHALL be 8-bit modulo 256, with no carry or borrow flags.
REQ-017 An insufficient depth SHALL raise underflow (code 2); opcodes 0xA (without macro) and 0xB-0xE SHALL raise illegal (code 3).
REQ-018 A faulting command SHALL leave the stack and depth unchanged.
REQ-019 Opcode 0xF CLR SHALL set depth=0, clear the error code and enter RUN, and SHALL be accepted in either state.
REQ-020 In ERROR, every accepted command other than CLR SHALL be ignored.
REQ-021 In RUN, io_out SHALL be the top entry, or 8'h00 when depth==0.
REQ-022 In ERROR, io_out SHALL be {4'hE, 2'b00, code[1:0]}.
REQ-023 The depth register SHALL be $clog2(DEPTH+1) bits wide and SHALL never exceed DEPTH.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL set depth=0, error code=0, state=RUN, strobe_q=0 and io_out=8'h00.
REQ-025 rst SHALL take priority over any command sampled on the same edge.
REQ-026 Reset mid-sequence SHALL discard the entire stack; stack storage contents need not be cleared.

Configuration
REQ-027 With macro STACKCALC_MUL_EN defined, opcode 0xA MUL SHALL pop b and a and push (a*b)[7:0], needing depth>=2.
REQ-028 Without STACKCALC_MUL_EN, the block SHALL contain no multiplier and opcode 0xA SHALL raise illegal (code 3).

Verification
REQ-029 Reset; push 3; push 5; ADD -> io_out 0x08, depth 1.
REQ-030 Push 0xA; SHL4; push 7; ADD -> io_out 0xA7; push 2; push 5; SUB -> io_out 0xFD.
REQ-031 DEPTH=8; 9 pushes -> io_out 0xE1; a further push is ignored (still 0xE1); CLR -> io_out 0x00, depth 0.
REQ-032 Empty stack; ADD -> io_out 0xE2; strobe held high 10 cycles with push 4 after CLR -> io_out 0x04, depth 1.
REQ-033 Push 6; push 7; MUL -> 0x2A with STACKCALC_MUL_EN, 0xE3 without; opcode 0xC -> 0xE3 in both builds.
REQ-034 Push 1; push 2; assert rst in the cycle of the SWAP strobe edge -> io_out 0x00, depth 0, state RUN.

Source files
------------

// File: rtl/stack_calc_core.sv
// Nibble-entry RPN stack calculator with RUN/ERROR states.
// Define STACKCALC_MUL_EN to enable opcode 0xA (8-bit multiply).
module stack_calc_core #(
    parameter int DEPTH = 8
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    typedef enum logic {ST_RUN, ST_ERR} state_t;

    logic       clk;
    logic       rst;
    logic       strobe;
    logic       mode;
    logic [3:0] payload;

    assign clk     = io_in[0];
    assign rst     = io_in[1];
    assign strobe  = io_in[2];
    assign mode    = io_in[3];
    assign payload = io_in[7:4];

    state_t        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [1:0]    code_q, code_d;
    logic          strobe_q;
    logic [7:0]    stack_q [DEPTH];
    logic [7:0]    stack_d [DEPTH];

    logic          accept;
    logic [DW-1:0] dm1;
    logic [IW-1:0] top_i, nxt_i, push_i;
    logic [7:0]    a, b, alu;
    logic          has1, has2, full;
    logic [1:0]    fault;

    logic is_push, is_bin, is_mul, is_neg, is_dup;
    logic is_drop, is_swap, is_shl, is_clr;

    assign accept = strobe & ~strobe_q;
    assign dm1    = depth_q - DW'(1);
    assign top_i  = IW'(dm1);
    assign nxt_i  = IW'(depth_q - DW'(2));
    assign push_i = IW'(depth_q);
    assign b      = stack_q[top_i];
    assign a      = stack_q[nxt_i];
    assign has1   = depth_q != '0;
    assign has2   = depth_q >= DW'(2);
    assign full   = depth_q == FULL;

`ifdef STACKCALC_MUL_EN
    assign is_mul = mode & (payload == 4'hA);
`else
    assign is_mul = 1'b0;
`endif
    assign is_push = ~mode;
    assign is_bin  = (mode & (payload <= 4'h4)) | is_mul;
    assign is_neg  = mode & (payload == 4'h5);
    assign is_dup  = mode & (payload == 4'h6);
    assign is_drop = mode & (payload == 4'h7);
    assign is_swap = mode & (payload == 4'h8);
    assign is_shl  = mode & (payload == 4'h9);
    assign is_clr  = mode & (payload == 4'hF);

    // Two-operand ALU: a is second-from-top, b is top.
    always_comb begin
        alu = a + b;
        case (payload)
            4'h1:    alu = a - b;
            4'h2:    alu = a & b;
            4'h3:    alu = a | b;
            4'h4:    alu = a ^ b;
`ifdef STACKCALC_MUL_EN
            4'hA:    alu = a * b;
`endif
            default: alu = a + b;
        endcase
    end

    // Command execution and RUN/ERROR next-state.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        code_d  = code_q;
        stack_d = stack_q;
        fault   = 2'd0;
        if (accept && is_clr) begin
            depth_d = '0;
            code_d  = 2'd0;
            state_d = ST_RUN;
        end else if (accept && state_q == ST_RUN) begin
            unique case (1'b1)
                is_push: begin
                    if (full) begin
                        fault = 2'd1;
                    end else begin
                        stack_d[push_i] = {4'h0, payload};
                        depth_d = depth_q + DW'(1);
                    end
                end
                is_bin: begin
                    if (!has2) begin
                        fault = 2'd2;
                    end else begin
                        stack_d[nxt_i] = alu;
                        depth_d = dm1;
                    end
                end
                is_neg: begin
                    if (!has1) fault = 2'd2;
                    else stack_d[top_i] = 8'h00 - b;
                end
                is_dup: begin
                    if (!has1) begin
                        fault = 2'd2;
                    end else if (full) begin
                        fault = 2'd1;
                    end else begin
                        stack_d[push_i] = b;
                        depth_d = depth_q + DW'(1);
                    end
                end
                is_drop: begin
                    if (!has1) fault = 2'd2;
                    else depth_d = dm1;
                end
                is_swap: begin
                    if (!has2) begin
                        fault = 2'd2;
                    end else begin
                        stack_d[top_i] = a;
                        stack_d[nxt_i] = b;
                    end
                end
                is_shl: begin
                    if (!has1) fault = 2'd2;
                    else stack_d[top_i] = {b[3:0], 4'h0};
                end
                default: fault = 2'd3;
            endcase
            if (fault != 2'd0) begin
                state_d = ST_ERR;
                code_d  = fault;
                depth_d = depth_q;
                stack_d = stack_q;
            end
        end
    end

    // Display: top of stack in RUN, error code in ERROR.
    always_comb begin
        io_out = 8'h00;
        if (state_q == ST_ERR) io_out = {4'hE, 2'b00, code_q};
        else if (has1) io_out = b;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            depth_q  <= '0;
            code_q   <= 2'd0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            code_q   <= code_d;
            strobe_q <= strobe;
        end
    end

    // Stack storage; never cleared, depth alone marks valid entries.
    always_ff @(posedge clk) begin
        if (!rst) stack_q <= stack_d;
    end

endmodule

// File: tb/tb_stack_calc_core.sv
// Directed bench for stack_calc_core (DEPTH=8).
// Expected values are hand-computed constants.
module tb_stack_calc_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] payload = 4'h0;
    logic [7:0] io_in;
    logic [7:0] io_out;
    int total = 0;
    int passed = 0;

    assign io_in = {payload, mode, strobe, rst, clk};

    stack_calc_core #(.DEPTH(8)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_depth(input string tag, input logic [7:0] exp);
        chk(tag, 8'(dut.depth_q), exp);
    endtask

    task automatic cmd(input logic m, input logic [3:0] p);
        @(negedge clk);
        mode = m;
        payload = p;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic push(input logic [3:0] p);
        cmd(1'b0, p);
    endtask

    task automatic op(input logic [3:0] p);
        cmd(1'b1, p);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_out", io_out, 8'h00);
        chk_depth("reset_depth", 8'd0);

        push(4'h3);
        chk("push3", io_out, 8'h03);
        push(4'h5);
        chk("push5", io_out, 8'h05);
        op(4'h0);
        chk("add", io_out, 8'h08);
        chk_depth("add_depth", 8'd1);

        push(4'hA);
        op(4'h9);
        chk("shl4", io_out, 8'hA0);
        push(4'h7);
        op(4'h0);
        chk("add_a7", io_out, 8'hA7);
        push(4'h2);
        push(4'h5);
        op(4'h1);
        chk("sub", io_out, 8'hFD);
        chk_depth("sub_depth", 8'd3);

        op(4'h4);
        chk("xor", io_out, 8'h5A);
        push(4'hF);
        op(4'h8);
        chk("swap", io_out, 8'h5A);
        op(4'h7);
        chk("drop", io_out, 8'h0F);
        op(4'h2);
        chk("and", io_out, 8'h08);
        op(4'h5);
        chk("neg", io_out, 8'hF8);
        op(4'h6);
        chk_depth("dup_depth", 8'd2);
        op(4'h3);
        chk("or", io_out, 8'hF8);
        op(4'h6);
        op(4'h0);
        chk("add_wrap", io_out, 8'hF0);
        op(4'hF);
        chk("clr", io_out, 8'h00);
        chk_depth("clr_depth", 8'd0);

        for (int i = 1; i <= 8; i++) push(4'(i));
        chk("full_top", io_out, 8'h08);
        chk_depth("full_depth", 8'd8);
        op(4'h6);
        chk("dup_full", io_out, 8'hE1);
        chk_depth("dup_full_depth", 8'd8);
        push(4'h1);
        chk("err_push_ignored", io_out, 8'hE1);
        op(4'h0);
        chk("err_add_ignored", io_out, 8'hE1);
        op(4'hF);
        chk("clr_err", io_out, 8'h00);

        for (int i = 1; i <= 9; i++) push(4'(i));
        chk("overflow", io_out, 8'hE1);
        chk_depth("overflow_depth", 8'd8);
        push(4'h3);
        chk("overflow_hold", io_out, 8'hE1);
        op(4'hF);
        chk("clr_ovf", io_out, 8'h00);
        chk_depth("clr_ovf_depth", 8'd0);

        op(4'h0);
        chk("underflow_add", io_out, 8'hE2);
        op(4'hF);
        @(negedge clk);
        mode = 1'b0;
        payload = 4'h4;
        strobe = 1'b1;
        repeat (10) @(negedge clk);
        strobe = 1'b0;
        chk("held_strobe", io_out, 8'h04);
        chk_depth("held_depth", 8'd1);
        op(4'h8);
        chk("swap_underflow", io_out, 8'hE2);
        chk_depth("swap_uf_depth", 8'd1);
        op(4'hF);
        op(4'h5);
        chk("neg_underflow", io_out, 8'hE2);
        op(4'hF);

        push(4'h6);
        push(4'h7);
        op(4'hA);
`ifdef STACKCALC_MUL_EN
        chk("mul", io_out, 8'h2A);
`else
        chk("mul_illegal", io_out, 8'hE3);
`endif
        op(4'hF);
        op(4'hC);
        chk("illegal_c", io_out, 8'hE3);
        op(4'hF);
        chk("clr_ill", io_out, 8'h00);

        push(4'h1);
        push(4'h2);
        @(negedge clk);
        mode = 1'b1;
        payload = 4'h8;
        strobe = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        strobe = 1'b0;
        chk("rst_prio_out", io_out, 8'h00);
        chk_depth("rst_prio_depth", 8'd0);
        push(4'h9);
        chk("run_after_rst", io_out, 8'h09);
        chk_depth("run_after_depth", 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
